// File: rtl/moore_seq_det_param.sv
// Moore serial pattern detector for any LEN-bit PATTERN with run-time overlap control.
// Define MATCH_CNT_EN to build the saturating match counter and its cnt_clr/match_cnt ports.
module moore_seq_det_param #(
  parameter int             LEN     = 5,
  parameter logic [LEN-1:0] PATTERN = 5'b10010,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic             overlap_en,
  output logic             out
`ifdef MATCH_CNT_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  localparam int SW    = $clog2(LEN + 1);
  localparam int TBL_W = (LEN + 1) * 2 * SW;
  localparam logic [SW-1:0] LAST = SW'(LEN);

  // Longest prefix of PATTERN that is a suffix of (matched prefix of length s) followed by bit b.
  function automatic int kmp_next(input int s, input int b);
    logic [LEN:0] seq;
    logic         ok;
    int           best;
    seq  = '0;
    best = 0;
    for (int i = 0; i < s; i++) seq[i] = PATTERN[LEN-1-i];
    seq[s] = b[0];
    for (int k = 1; k <= LEN; k++) begin
      if (k <= s + 1) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++) begin
          if (seq[s+1-k+j] != PATTERN[LEN-1-j]) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  // Entry (2*s + b) holds the next state for state s and input bit b.
  function automatic logic [TBL_W-1:0] build_tbl();
    logic [TBL_W-1:0] tbl;
    tbl = '0;
    for (int s = 0; s <= LEN; s++) begin
      for (int b = 0; b < 2; b++) begin
        tbl[(2*s+b)*SW +: SW] = SW'(kmp_next(s, b));
      end
    end
    return tbl;
  endfunction

  localparam logic [TBL_W-1:0] NXT_TBL = build_tbl();

  logic [SW-1:0] r_state;
  logic [SW-1:0] w_state_nxt;
  logic          r_out;
  logic          w_out_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '0;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
    end
  end

  // NOTE: defaulting w_state_nxt to the current state first keeps this block free of latches.
  always_comb begin
    w_state_nxt = r_state;
    if (in_valid) begin
      if (r_state == LAST && !overlap_en) begin
        w_state_nxt = (in == PATTERN[LEN-1]) ? SW'(1) : '0;
      end else begin
        w_state_nxt = NXT_TBL[(2*int'(r_state) + int'(in))*SW +: SW];
      end
    end
  end

  always_comb begin
    w_out_nxt = (w_state_nxt == LAST);
  end

  assign out = r_out;

`ifdef MATCH_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Clear wins over a simultaneous increment; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_cnt <= '0;
    end else if (in_valid && w_out_nxt && !(&r_cnt)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign match_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_moore_seq_det_param.sv
// Randomised and directed bench for moore_seq_det_param: a 10010 instance and a 1111 instance
// share one stimulus stream and are compared against a sliding-window reference model.
module tb_moore_seq_det_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, in_bit, overlap_en, cnt_clr;
  logic out_a, out_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  moore_seq_det_param #(.LEN(5), .PATTERN(5'b10010), .CNT_W(8)) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in         (in_bit),
    .overlap_en (overlap_en),
    .out        (out_a)
`ifdef MATCH_CNT_EN
    ,
    .cnt_clr    (cnt_clr),
    .match_cnt  (cnt_a)
`endif
  );

  moore_seq_det_param #(.LEN(4), .PATTERN(4'b1111), .CNT_W(2)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in         (in_bit),
    .overlap_en (overlap_en),
    .out        (out_b)
`ifdef MATCH_CNT_EN
    ,
    .cnt_clr    (cnt_clr),
    .match_cnt  (cnt_b)
`endif
  );

`ifndef MATCH_CNT_EN
  assign cnt_a = '0;
  assign cnt_b = '0;
`endif

  // Reference: bits received since the last restart; a match is the last LEN of them equal to PATTERN.
  typedef struct packed {
    logic [63:0] win;
    int unsigned n;
    logic        out;
    int unsigned cnt;
  } model_t;

  model_t ma, mb;
  int n_checks = 0;
  int n_bad    = 0;
  int pulses_a = 0;
  int pulses_b = 0;

  function automatic model_t step(input model_t m, input int len, input logic [31:0] pat,
                                  input int unsigned cmax, input logic r, input logic v,
                                  input logic b, input logic ovl, input logic clr);
    model_t      nm;
    logic [63:0] msk;
    nm  = m;
    msk = (64'd1 << len) - 64'd1;
    if (r) begin
      nm = '0;
    end else begin
      if (v) begin
        if (nm.out && !ovl) nm.n = 0;
        nm.win = {nm.win[62:0], b};
        if (nm.n < 64) nm.n = nm.n + 1;
        nm.out = (nm.n >= len) && ((nm.win & msk) == {32'b0, pat});
        if (nm.out && nm.cnt < cmax) nm.cnt = nm.cnt + 1;
      end
      if (clr) nm.cnt = 0;
    end
    return nm;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic b, input logic ovl, input logic clr);
    rst = r; in_valid = v; in_bit = b; overlap_en = ovl; cnt_clr = clr;
    @(posedge clk);
    #1;
    ma = step(ma, 5, 32'b10010, 255, r, v, b, ovl, clr);
    mb = step(mb, 4, 32'b1111, 3, r, v, b, ovl, clr);
    check("out_a", {31'b0, out_a}, {31'b0, ma.out});
    check("out_b", {31'b0, out_b}, {31'b0, mb.out});
`ifdef MATCH_CNT_EN
    check("cnt_a", {24'b0, cnt_a}, ma.cnt);
    check("cnt_b", {30'b0, cnt_b}, mb.cnt);
`endif
    pulses_a += int'(out_a);
    pulses_b += int'(out_b);
  endtask

  // Sends seq[n-1] first, with in_valid high on every cycle.
  task automatic send(input logic [15:0] seq, input int n, input logic ovl);
    for (int i = n - 1; i >= 0; i--) cyc(1'b0, 1'b1, seq[i], ovl, 1'b0);
  endtask

  task automatic restart();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    pulses_a = 0;
    pulses_b = 0;
  endtask

  initial begin
    ma = '0;
    mb = '0;
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; overlap_en = 1'b1; cnt_clr = 1'b0;

    // Reset held with live input
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("rst_out", {31'b0, out_a}, 32'd0);
    check("rst_cnt", {24'b0, cnt_a}, 32'd0);
    pulses_a = 0;
    send(16'b1001, 4, 1'b1);
    check("s1_early", pulses_a, 0);
    send(16'b0, 1, 1'b1);
    check("s1_hit", {31'b0, out_a}, 32'd1);

    // Overlap vs non-overlap on 10010010
    restart();
    send(16'b10010010, 8, 1'b1);
    check("s2_pulses", pulses_a, 2);
    check("s2_last", {31'b0, out_a}, 32'd1);
`ifdef MATCH_CNT_EN
    check("s2_cnt", {24'b0, cnt_a}, 32'd2);
`endif
    restart();
    send(16'b10010010, 8, 1'b0);
    check("s3_pulses", pulses_a, 1);
    check("s3_last", {31'b0, out_a}, 32'd0);
`ifdef MATCH_CNT_EN
    check("s3_cnt", {24'b0, cnt_a}, 32'd1);
`endif

    // Gaps in in_valid, then the same with a reset inside the gap
    restart();
    send(16'b10, 2, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send(16'b010, 3, 1'b1);
    check("s4_gap_hit", {31'b0, out_a}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("s4_hold", {31'b0, out_a}, 32'd1);
    restart();
    send(16'b10, 2, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send(16'b010, 3, 1'b1);
    check("s4_rst_gap", {31'b0, out_a}, 32'd0);
    check("s4_rst_pulses", pulses_a, 0);

    // Single match inside a longer stream
    restart();
    send(16'b010110010, 9, 1'b1);
    check("s5_at9", {31'b0, out_a}, 32'd1);
    send(16'b1101, 4, 1'b1);
    check("s5_pulses", pulses_a, 1);

    // Periodic pattern 1111 with saturating 2-bit counter
    restart();
    send(16'b1111111, 7, 1'b1);
    check("s6_pulses", pulses_b, 4);
`ifdef MATCH_CNT_EN
    check("s6_sat", {30'b0, cnt_b}, 32'd3);
`endif
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("s6_clr_out", {31'b0, out_b}, 32'd1);
`ifdef MATCH_CNT_EN
    check("s6_clr_cnt", {30'b0, cnt_b}, 32'd0);
`endif

    // Random traffic: occasional resets/clears, mode flips, segments biased toward 1s
    begin
      logic ovl;
      logic bias;
      ovl  = 1'b1;
      bias = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        logic r, v, b, clr;
        if ($urandom % 32 == 0) ovl = ~ovl;
        if ($urandom % 100 == 0) bias = ~bias;
        r   = ($urandom % 64 == 0);
        v   = ($urandom % 4 != 0);
        b   = bias ? ($urandom % 5 != 0) : 1'($urandom % 2);
        clr = ($urandom % 32 == 0);
        cyc(r, v, b, ovl, clr);
      end
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
